aes_key_expand_seq: RTL and testbench
=====================================

Name: aes_key_expand_seq

Overview:
- Iterative AES-128 key schedule that feeds the Cipher and DeCipher datapaths; it sits directly upstream of both.
- Computes round keys 0..10 from a 128-bit cipher key, one round key per clock.
- Stores all round keys in a register file. Cipher reads by ascending index; DeCipher reads by descending index.
- Provides a start/busy/done handshake so the board top can trigger expansion from a debounced KEY press.

Parameters:
- NR, 10, number of rounds. Only 10 is supported; any other value is a compile-time error.
- KEY_BITS, 128, cipher key width. Fixed at 128, Nk = 4.

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- rst  input  1  reset. Asynchronous, active-high; clears all state.
- start  input  1  single-cycle request to begin expansion. Sampled only in IDLE or DONE.
- key_in  input  [0:127]  cipher key, MSB-first byte order (byte 0 = bits 0:7). Sampled only on the accepted start cycle.
- busy  output  1  high while expansion is in progress.
- done  output  1  one-cycle pulse after round key NR is written.
- keys_valid  output  1  high once all round keys are valid; stays high until next accepted start or rst.
- rd_idx  input  4  round key select, 0..NR.
- rd_key  output  [0:127]  round key rd_idx, combinational read of the register file. Returns 0 if rd_idx > NR.
- last_key  output  [0:127]  round key NR, provided directly for DeCipher's initial AddRoundKey.

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, keys_valid=0, all round-key registers=0, round counter=0, rcon=8'h01. Consequently rd_key=0 and last_key=0.
- States:
  - IDLE: on start, go to EXPAND.
  - EXPAND: stays for NR cycles, then goes to DONE.
  - DONE: on start, go to EXPAND. Otherwise hold.
- Accepted start (edge E0): rk[0]<=key_in, ctr<=1, rcon<=8'h01, busy<=1, keys_valid<=0, go to EXPAND.
- Each EXPAND edge for r=ctr (1..NR), with w0..w3 = the 32-bit words of rk[r-1]:
  - t = SubWord(RotWord(w3)) xor {rcon,24'h0}
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2
  - rk[r]<={n0,n1,n2,n3}, ctr<=ctr+1, rcon<=xtime(rcon)
- xtime rule: (rcon<<1) xor (rcon[7] ? 8'h1b : 8'h00), truncated to 8 bits. Required sequence: 01,02,04,08,10,20,40,80,1b,36.
- Latency: rk[0] is written at E0 and rk[r] at edge E0+r. At edge E0+NR: busy<=0, done<=1, keys_valid<=1, state<=DONE. done clears at the next edge. Total: done is visible NR cycles after the start cycle.
- start while busy is ignored; key_in changes during EXPAND have no effect.
- start in DONE restarts expansion: keys_valid drops at the next edge, and stale rk[1..NR] remain readable until overwritten. Consumers must gate on keys_valid.
- start held high continuously: re-accepted in DONE, so the block expands repeatedly. Each pass is legal.
- rst asserted mid-expansion: immediately returns to reset values. No partial keys_valid.
- rd_idx/rd_key read path is purely combinational and has no effect on state.

Decomposition:
- Package aes_pkg holds:
  - state enum {IDLE, EXPAND, DONE}
  - constants NR=10, NK=4
  - 32-bit word type and 128-bit block type
  - xtime function and RotWord function
- Sub-module aes_sbox: combinational 8-bit forward S-box. Instantiated 4 times for SubWord and shared with Cipher's SubBytes.

Test Plan:
- rst, start with key_in=2b7e151628aed2a6abf7158809cf4f3c:
  - done pulses exactly 10 cycles after start.
  - rd_idx=1 gives a0fafe1788542cb123a339392a6c7605.
  - last_key = d014f9a8c9ee2589e13f0cc8b6630ca6.
- key_in=000102030405060708090a0b0c0d0e0f:
  - rd_idx=0 returns key_in.
  - last_key = 13111d7fe3944a17f307a78b4d2b30c5.
  - rd_idx=11..15 returns 0.
- start pulsed at cycles 3 and 6 after the first accepted start, with key_in changed each time: ignored. busy stays high, done occurs once, and the keys match the first key.
- rst asserted at cycle 5 of expansion: all outputs return to 0 asynchronously. A new start then completes correctly with FIPS values.
- Restart from DONE with the second FIPS key:
  - keys_valid falls the cycle after start and rises with done.
  - last_key updates to 13111d7f...
- Internal probe: rcon over ten expansion cycles equals 01,02,04,08,10,20,40,80,1b,36.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte/word helpers for the key schedule
// and the Cipher/DeCipher datapaths.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    localparam int NR = 10;
    localparam int NK = 4;

    typedef logic [31:0] word_t;
    typedef logic [0:127] block_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: GF(2^8) inverse followed by the affine map.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] x,
    output logic [7:0] s
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p  = '0;
        aa = a;
        bb = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse and conveniently maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r, base, e;
        r    = 8'h01;
        base = a;
        e    = 8'd254;
        for (int unsigned i = 0; i < 8; i++) begin
            if (e[i]) r = gf_mul(r, base);
            base = gf_mul(base, base);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        s = affine(gf_inv(x));
    end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128 key schedule: one round key per clock into a register file
// readable by index, with start/busy/done handshake.
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int NR       = 10,
    parameter int KEY_BITS = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [0:127] key_in,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    input  logic [3:0]   rd_idx,
    output logic [0:127] rd_key,
    output logic [0:127] last_key
);

    generate
        if (NR != aes_pkg::NR || KEY_BITS != 128) begin : g_param_check
            $error("aes_key_expand_seq supports only NR=10, KEY_BITS=128");
        end
    endgenerate

    state_t     state, state_nxt;
    logic [3:0] ctr;
    logic [7:0] rcon;
    logic       done_q;
    block_t     rk [0:NR];
    block_t     cur;
    block_t     nxt;
    word_t      w3_rot, sub, t, n0, n1, n2, n3;
    logic       accept;

    assign accept = start && (state == IDLE || state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = EXPAND;
            EXPAND:  if (ctr == 4'(NR)) state_nxt = DONE;
            DONE:    if (start) state_nxt = EXPAND;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // cur mirrors rk[ctr-1] so the round function never needs a variable read port.
    assign w3_rot = rot_word(cur[96:127]);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .x (w3_rot[8*i +: 8]),
            .s (sub[8*i +: 8])
        );
    end

    assign t   = sub ^ {rcon, 24'h0};
    assign n0  = cur[0:31]   ^ t;
    assign n1  = cur[32:63]  ^ n0;
    assign n2  = cur[64:95]  ^ n1;
    assign n3  = cur[96:127] ^ n2;
    assign nxt = {n0, n1, n2, n3};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i <= unsigned'(NR); i++) rk[i] <= '0;
            cur    <= '0;
            ctr    <= '0;
            rcon   <= 8'h01;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                rk[0] <= key_in;
                cur   <= key_in;
                ctr   <= 4'd1;
                rcon  <= 8'h01;
            end else if (state == EXPAND) begin
                rk[ctr] <= nxt;
                cur     <= nxt;
                ctr     <= ctr + 4'd1;
                rcon    <= xtime(rcon);
                if (ctr == 4'(NR)) done_q <= 1'b1;
            end
        end
    end

    assign busy       = (state == EXPAND);
    assign keys_valid = (state == DONE);
    assign done       = done_q;
    assign last_key   = rk[NR];

    always_comb begin
        rd_key = '0;
        if (rd_idx <= 4'(NR)) rd_key = rk[rd_idx];
    end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed bench for aes_key_expand_seq using FIPS-197 key schedule vectors.
module tb_aes_key_expand_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [0:127] key_in;
    logic         busy, done, keys_valid;
    logic [3:0]   rd_idx;
    logic [0:127] rd_key, last_key;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    localparam logic [0:127] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [0:127] K1_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [0:127] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [0:127] K2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] K2_R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [0:127] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic [7:0] rcon_exp [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                   8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    always #5 clk = ~clk;

    aes_key_expand_seq #(.NR(10), .KEY_BITS(128)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key),
        .last_key   (last_key)
    );

    task automatic chk(input string tag, input logic [0:127] obs, input logic [0:127] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] idx, input logic [0:127] exp);
        rd_idx = idx;
        #1;
        chk(tag, rd_key, exp);
    endtask

    // Issue a one-cycle start; returns at the falling edge after the accepting edge.
    task automatic kick(input logic [0:127] k);
        @(negedge clk);
        start  = 1'b1;
        key_in = k;
        @(negedge clk);
        start  = 1'b0;
        key_in = ~k;
    endtask

    // Follows one expansion pass from the falling edge after the accepting edge.
    task automatic follow(input bit inject);
        chk("rcon_r1", 128'(dut.rcon), 128'(rcon_exp[0]));
        chk("busy_after_start", 128'(busy), 128'(1'b1));
        chk("kv_after_start", 128'(keys_valid), 128'(1'b0));
        for (int c = 1; c <= 10; c++) begin
            if (inject && (c == 3 || c == 6)) begin
                start  = 1'b1;
                key_in = {4{32'hdeadbeef}} ^ 128'(c);
            end
            @(negedge clk);
            start = 1'b0;
            if (c < 10) begin
                chk("busy_during", 128'(busy), 128'(1'b1));
                chk("done_early", 128'(done), 128'(1'b0));
                chk("kv_during", 128'(keys_valid), 128'(1'b0));
                chk("rcon_seq", 128'(dut.rcon), 128'(rcon_exp[c]));
            end else begin
                chk("done_pulse", 128'(done), 128'(1'b1));
                chk("busy_end", 128'(busy), 128'(1'b0));
                chk("kv_end", 128'(keys_valid), 128'(1'b1));
            end
        end
        @(negedge clk);
        chk("done_clear", 128'(done), 128'(1'b0));
        chk("kv_hold", 128'(keys_valid), 128'(1'b1));
    endtask

    initial begin
        rst    = 1'b0;
        start  = 1'b0;
        key_in = '0;
        rd_idx = 4'd0;
        #1 rst = 1'b1;
        #2;
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_done", 128'(done), 128'(1'b0));
        chk("rst_kv", 128'(keys_valid), 128'(1'b0));
        chk("rst_last", last_key, '0);
        chk("rst_rd0", rd_key, '0);
        chk("rst_rcon", 128'(dut.rcon), 128'(8'h01));
        @(negedge clk);
        rst = 1'b0;

        // First FIPS key from IDLE
        kick(K1);
        follow(1'b0);
        rd_chk("k1_rd0", 4'd0, K1);
        rd_chk("k1_rd1", 4'd1, K1_R1);
        rd_chk("k1_rd2", 4'd2, K1_R2);
        rd_chk("k1_rd10", 4'd10, K1_R10);
        chk("k1_last", last_key, K1_R10);

        // Restart from DONE with the second key; stale keys remain until overwritten
        kick(K2);
        chk("restart_stale_last", last_key, K1_R10);
        follow(1'b0);
        chk("k2_last", last_key, K2_R10);
        rd_chk("k2_rd0", 4'd0, K2);
        rd_chk("k2_rd1", 4'd1, K2_R1);
        for (int i = 11; i <= 15; i++) rd_chk("rd_oob", 4'(i), '0);

        // Starts during expansion are ignored
        kick(K1);
        follow(1'b1);
        rd_chk("ign_rd0", 4'd0, K1);
        rd_chk("ign_rd1", 4'd1, K1_R1);
        chk("ign_last", last_key, K1_R10);

        // Asynchronous reset mid-expansion
        kick(K2);
        repeat (4) @(negedge clk);
        chk("mid_busy", 128'(busy), 128'(1'b1));
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 128'(busy), 128'(1'b0));
        chk("arst_done", 128'(done), 128'(1'b0));
        chk("arst_kv", 128'(keys_valid), 128'(1'b0));
        chk("arst_last", last_key, '0);
        rd_chk("arst_rd1", 4'd1, '0);
        @(negedge clk);
        rst = 1'b0;
        kick(K1);
        follow(1'b0);
        rd_chk("post_rst_rd1", 4'd1, K1_R1);
        chk("post_rst_last", last_key, K1_R10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
